mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Sequences the MAR, MDR and 512-word RAM for every memory transaction in the CPU, sharing that path between two requesters. Requester 0 is instruction fetch, which only reads. Requester 1 is load/store data access, which reads or writes. The block arbitrates between them round-robin, drives MARIn, MDRIn, Read and the RAM strobes in the correct cycle order, and returns a one-cycle grant and a one-cycle done pulse to the winning requester.

Parameters:
RAM_LAT, 1, RAM read latency in cycles from the first mem_rd cycle to valid data; legal range 0..7.
CNT_W, 3, width of the latency counter; must satisfy 2^CNT_W > RAM_LAT.

Ports:
clk  in  1  system clock, rising edge.
Clear  in  1  asynchronous, active-low reset.
fetch_req  in  1  fetch requester wants a read; held until fetch_gnt.
data_req  in  1  data requester wants an access; held until data_gnt.
data_we  in  1  access direction for data_req: 1 = write, 0 = read; sampled with data_req.
fetch_gnt  out  1  fetch owns the bus this cycle and must drive its address onto BusMuxOut.
data_gnt  out  1  data owns the bus this cycle and must drive its address onto BusMuxOut.
MARIn  out  1  MAR load enable; asserted in the grant cycle.
mem_rd  out  1  RAM read strobe.
mem_we  out  1  RAM write strobe, using the current MAR address and MDR contents.
Read  out  1  MDR input-mux select: RAM data to MDR.
MDRIn  out  1  MDR load enable.
fetch_done  out  1  one-cycle pulse when the fetch transaction completes.
data_done  out  1  one-cycle pulse when the data transaction completes.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- States are IDLE, ADDR, RWAIT, CAPT and WR. All outputs decode combinationally from the registered state and owner only; there are no paths from the request inputs to the outputs.
- Reset: while Clear = 0, state = IDLE, owner = 0, lat_cnt = 0 and last_owner = 1, so fetch wins the first contention. All outputs are 0.
- IDLE, with no request: stay in IDLE.
- IDLE, with any request: choose the winner and go to ADDR.
  - Only one request asserted: that requester wins.
  - Both asserted: the winner is the requester that is not last_owner.
  - On the transition: latch owner = winner and op_we = (winner == data) & data_we; update last_owner = winner.
- ADDR, exactly 1 cycle:
  - Assert MARIn and the owner's gnt.
  - If op_we = 1, go to WR.
  - Else if RAM_LAT = 0, go to CAPT.
  - Else load lat_cnt = RAM_LAT - 1 and go to RWAIT.
- RWAIT: assert mem_rd. Decrement lat_cnt each cycle; go to CAPT in the cycle lat_cnt == 0. This state lasts exactly RAM_LAT cycles.
- CAPT, 1 cycle: assert mem_rd, Read, MDRIn and the owner's done, then return to IDLE.
- WR, 1 cycle: assert mem_we and data_done, then return to IDLE.
  - The data requester must have loaded MDR before requesting. This block never drives MDRIn on writes.
- Latency, with request asserted in IDLE cycle t:
  - gnt and MARIn in cycle t+1.
  - Read done in cycle t+2+RAM_LAT.
  - Write done in cycle t+2.
- Throughput: one transaction per 3+RAM_LAT cycles for reads, one per 3 cycles for writes. IDLE always occupies at least one cycle between transactions.
- Requests arriving while busy are ignored until IDLE. A request deasserted before its grant is withdrawn with no side effects.
- Once in ADDR, the transaction always runs to completion regardless of request inputs. data_we changes after the grant have no effect.
- Clear asserted in any state: immediately return to IDLE with all outputs 0. The transaction in flight is abandoned, no done pulse is produced, and the requester must re-request.
- Exactly one of fetch_gnt/data_gnt can be high per cycle, and likewise one of fetch_done/data_done. mem_we and MDRIn are never high in the same cycle.

Test Plan:
- Reset: hold Clear = 0 with both requests high for 3 cycles, then release -> all outputs 0 during reset; first grant is fetch_gnt, 1 cycle after release.
- Single fetch, RAM_LAT = 1: fetch_req high at cycle 0 -> fetch_gnt and MARIn at cycle 1; mem_rd at cycles 2 and 3; Read, MDRIn and fetch_done at cycle 3; busy low at cycle 4.
- Data write: data_req = 1, data_we = 1 at cycle 0 -> data_gnt and MARIn at cycle 1; mem_we and data_done at cycle 2; MDRIn and Read stay 0 throughout.
- Contention: both requests held high continuously -> grant order fetch, data, fetch, data; each grant follows a done pulse by exactly 2 cycles.
- Clear = 0 during RWAIT with RAM_LAT = 3 -> all outputs 0 immediately; no fetch_done; after release, a new fetch_req gets a grant 1 cycle later.
- RAM_LAT = 0 build, data read with data_we = 0 -> data_gnt at cycle 1; Read, MDRIn, mem_rd and data_done at cycle 2; RWAIT is never entered.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: arbitrates fetch (owner 0) and data (owner 1) round-robin
// and steps MAR/RAM/MDR control through ADDR, RWAIT, CAPT or WR.
module mem_access_ctrl #(
  parameter int RAM_LAT = 1,
  parameter int CNT_W   = 3
) (
  input  logic clk,
  input  logic Clear,
  input  logic fetch_req,
  input  logic data_req,
  input  logic data_we,
  output logic fetch_gnt,
  output logic data_gnt,
  output logic MARIn,
  output logic mem_rd,
  output logic mem_we,
  output logic Read,
  output logic MDRIn,
  output logic fetch_done,
  output logic data_done,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RWAIT,
    S_CAPT,
    S_WR
  } state_t;

  localparam logic [CNT_W-1:0] LAT_LOAD = (RAM_LAT > 0) ? CNT_W'(RAM_LAT - 1) : '0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_owner;
  logic             r_last_owner;
  logic             r_op_we;
  logic [CNT_W-1:0] r_lat_cnt;
  logic             w_any_req;
  logic             w_winner;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    w_any_req = fetch_req | data_req;
    if (fetch_req && data_req) begin
      w_winner = ~r_last_owner;
    end else begin
      w_winner = data_req;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (r_op_we) begin
          w_state_nxt = S_WR;
        end else if (RAM_LAT == 0) begin
          w_state_nxt = S_CAPT;
        end else begin
          w_state_nxt = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (r_lat_cnt == '0) begin
          w_state_nxt = S_CAPT;
        end
      end
      S_CAPT:  w_state_nxt = S_IDLE;
      S_WR:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_op_we      <= 1'b0;
      r_lat_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any_req) begin
        r_owner      <= w_winner;
        r_last_owner <= w_winner;
        r_op_we      <= w_winner & data_we;
      end
      if (r_state == S_ADDR && !r_op_we) begin
        r_lat_cnt <= LAT_LOAD;
      end else if (r_state == S_RWAIT && r_lat_cnt != '0) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end
    end
  end

  // Outputs depend only on registered state and owner, never on the request inputs.
  always_comb begin
    fetch_gnt  = 1'b0;
    data_gnt   = 1'b0;
    MARIn      = 1'b0;
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    Read       = 1'b0;
    MDRIn      = 1'b0;
    fetch_done = 1'b0;
    data_done  = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_ADDR: begin
        MARIn     = 1'b1;
        fetch_gnt = ~r_owner;
        data_gnt  = r_owner;
      end
      S_RWAIT: begin
        mem_rd = 1'b1;
      end
      S_CAPT: begin
        mem_rd     = 1'b1;
        Read       = 1'b1;
        MDRIn      = 1'b1;
        fetch_done = ~r_owner;
        data_done  = r_owner;
      end
      S_WR: begin
        mem_we    = 1'b1;
        data_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
